// File: rtl/gate_arb_pkg.sv
// Shared definitions for the round-robin gated AND arbiter: FSM encodings
// and the default requester count / operand width.
package gate_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Shared combinational resource: W-bit bitwise AND of two operands.
module logic_unit #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);

    assign o_y = i_a & i_b;

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter granting N_REQ requesters one at a time access to a
// single shared AND unit; each operation takes grant, execute and done cycles.
module gate_arbiter
    import gate_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       a_in,
    input  logic [N_REQ*W-1:0]       b_in,
    output logic [N_REQ-1:0]         gnt,
    output logic [W-1:0]             q,
    output logic                     q_valid,
    output logic [$clog2(N_REQ)-1:0] q_id,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [W-1:0]     r_q;
    logic             r_q_valid;
    logic [IW-1:0]    r_q_id;
    logic             r_busy;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_idx;
    logic [W-1:0]     r_a_lat;
    logic [W-1:0]     r_b_lat;

    logic             w_found;
    logic [IW-1:0]    w_cand;
    logic [IW-1:0]    w_win;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [W-1:0]     w_a_sel;
    logic [W-1:0]     w_b_sel;
    logic [W-1:0]     w_and;

    logic_unit #(.W(W)) u_logic_unit (
        .i_a (r_a_lat),
        .i_b (r_b_lat),
        .o_y (w_and)
    );

    // Round-robin winner search starting just above the last served requester
    always_comb begin
        w_found   = 1'b0;
        w_cand    = '0;
        w_win     = '0;
        w_gnt_nxt = '0;
        w_a_sel   = '0;
        w_b_sel   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand  = IW'((int'(r_ptr) + off) % N_REQ);
            w_win   = (!w_found && req[w_cand]) ? w_cand : w_win;
            w_found = w_found | req[w_cand];
        end
        w_gnt_nxt[w_win] = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            w_a_sel = (w_win == IW'(i)) ? a_in[i*W +: W] : w_a_sel;
            w_b_sel = (w_win == IW'(i)) ? b_in[i*W +: W] : w_b_sel;
        end
    end

    // Operation sequencer with registered grant, result and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_q_id    <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= IW'(N_REQ - 1);
            r_idx     <= '0;
            r_a_lat   <= '0;
            r_b_lat   <= '0;
        end else begin
            r_q_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt_nxt;
                        r_idx   <= w_win;
                        r_a_lat <= w_a_sel;
                        r_b_lat <= w_b_sel;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end else begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_q     <= w_and;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_q_valid <= 1'b1;
                    r_q_id    <= r_idx;
                    r_ptr     <= r_idx;
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet idle
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign q_id    = r_q_id;
    assign busy    = r_busy;

endmodule

// File: doc/gate_arbiter.md
GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the AND unit (2..8).
REQ-002 Parameter W, default 8: operand/result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester request; held high until done for that requester.
REQ-006 a_in  input  N_REQ*W  operand A; slice i = bits [i*W +: W].
REQ-007 b_in  input  N_REQ*W  operand B; same slicing.
REQ-008 gnt  output  N_REQ  one-hot grant; all-zero when idle.
REQ-009 q  output  W  result of granted operation.
REQ-010 q_valid  output  1  one-cycle pulse; q and q_id valid.
REQ-011 q_id  output  clog2(N_REQ)  index of requester owning q.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; encoded 2 bits.
REQ-014 IDLE: with any req bit high, SHALL select the winner round-robin, searching from ptr+1 upward with wrap; registers gnt one-hot and latches that requester's a/b slices; next state EXEC.
REQ-015 IDLE with req all zero SHALL remain IDLE; gnt=0.
REQ-016 EXEC: shared unit computes a_lat & b_lat (bitwise, W bits); result registered into q; next state DONE.
REQ-017 DONE: q_valid=1 for exactly this cycle; q_id = granted index; ptr <= granted index; gnt cleared; next state IDLE.
REQ-018 Latency: req sampled high in IDLE at edge t -> gnt high after t; q_valid high after edge t+2; one operation per 3 cycles maximum throughput.
REQ-019 Operands SHALL be latched at grant; changes to a_in/b_in or deasserting req during EXEC/DONE SHALL NOT alter q or abort the operation.
REQ-020 Requests arriving while busy SHALL wait; no request is dropped while its req stays high.
REQ-021 Fairness: with all requesters continuously requesting, grants SHALL rotate 0,1,2,...,N_REQ-1,0 (after reset, ptr = N_REQ-1 so requester 0 wins first).
REQ-022 Simultaneous requests: only one winner per arbitration; others SHALL be served within N_REQ-1 further operations.
REQ-023 q SHALL hold its value between pulses; q_id holds likewise.
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 rst high SHALL immediately force: state IDLE, gnt=0, q=0, q_valid=0, q_id=0, busy=0, ptr=N_REQ-1, latched operands 0.
REQ-026 rst asserted mid-operation SHALL abort it; no q_valid pulse is emitted for the aborted operation.
REQ-027 First arbitration SHALL occur at the first rising edge after rst deasserts.

Structure
REQ-028 Shared package gate_arb_pkg SHALL hold the FSM state encodings and default N_REQ/W constants.
REQ-029 One sub-module logic_unit (W-bit bitwise AND, purely combinational) SHALL be instantiated once as the shared resource.
REQ-030 Round-robin selection logic SHALL be combinational inside gate_arbiter; target size 120-400 RTL lines.

Verification
REQ-031 Single request: req=4'b0100, a slice2=8'hF0, b slice2=8'h3C -> gnt=4'b0100 one cycle later, q=8'h30, q_id=2, q_valid pulse two cycles after grant edge.
REQ-032 All request: req=4'b1111 held, distinct operands -> q_id sequence 0,1,2,3,0, each q_valid 3 cycles apart.
REQ-033 Operand change after grant: requester 1 a=8'hFF,b=8'h0F, change a to 8'h00 in EXEC -> q=8'h0F.
REQ-034 Reset mid-EXEC: assert rst during EXEC -> gnt=0, q=0 immediately, no q_valid; after release, req=4'b0001 -> requester 0 served.
REQ-035 Late arrival: req=4'b0001 served; req=4'b0010 rises during EXEC -> requester 1 granted on the edge after DONE, q_id=1.
REQ-036 Idle: req=0 for 20 cycles -> busy=0, gnt=0, q_valid never asserted.
